// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the M-stage data-memory stall controller.
package mem_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must be able to hold the limit itself; never narrower than one bit.
  function automatic int timeoutCntWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int TIMEOUT_CNT_W = timeoutCntWidth(TIMEOUT_DEF);

endpackage

// File: rtl/mem_stall_ctrl.sv
// Sequences M-stage loads/stores over a valid/ready request + valid response bus.
// Latency: >=3 frozen cycles per access (IDLE-detect, REQ, WAIT), then one released DONE cycle.
// Backpressure: REQ holds request stable until req_ready; MEM_TIMEOUT_EN adds a WAIT watchdog.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] AddrM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            HazStallF,
  input  logic            HazStallD,
  input  logic            HazFlushE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushE,
  output logic            FlushW,
  output logic [XLEN-1:0] ReadDataM,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_we,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic            BusErr
);

  state_t          state;
  state_t          stateNext;
  logic            memOp;
  logic            memBusy;
  logic            timeoutHit;
  logic            reqWeQ;
  logic [XLEN-1:0] reqAddrQ;
  logic [XLEN-1:0] reqWdataQ;

  assign memOp = MemReadM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = timeoutCntWidth(TIMEOUT_CYCLES);

  logic [CntW-1:0] waitCnt;
  logic            busErrQ;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a response in that cycle takes priority.
  assign timeoutHit = (state == WAIT) && !rsp_valid &&
                      (waitCnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt <= '0;
      busErrQ <= 1'b0;
    end else begin
      if (state == REQ && req_ready) begin
        waitCnt <= '0;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (timeoutHit) begin
        busErrQ <= 1'b1;
      end
    end
  end

  assign BusErr = busErrQ;
`else
  localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;

  assign timeoutHit = 1'b0;
  assign BusErr     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (memOp)                   stateNext = REQ;
      REQ:  if (req_ready)               stateNext = WAIT;
      WAIT: if (rsp_valid || timeoutHit) stateNext = DONE;
      DONE:                              stateNext = IDLE;
      default:                           stateNext = IDLE;
    endcase
  end

  // Request registers are captured once in IDLE and held through REQ/WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reqWeQ    <= 1'b0;
      reqAddrQ  <= '0;
      reqWdataQ <= '0;
      ReadDataM <= '0;
    end else begin
      if (state == IDLE && memOp) begin
        reqWeQ    <= MemWriteM;
        reqAddrQ  <= AddrM;
        reqWdataQ <= WriteDataM;
      end
      if (state == WAIT && rsp_valid) begin
        if (!reqWeQ) begin
          ReadDataM <= rsp_rdata;
        end
      end else if (timeoutHit) begin
        ReadDataM <= '0;
      end
    end
  end

  // Output logic: a busy access freezes every stage and bubbles W; E is held so FlushE is dropped.
  always_comb begin
    memBusy   = ((state == IDLE) && memOp) || (state == REQ) || (state == WAIT);
    req_valid = (state == REQ);
    req_we    = reqWeQ;
    req_addr  = reqAddrQ;
    req_wdata = reqWdataQ;
    if (memBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = HazStallF;
      StallD = HazStallD;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushE = HazFlushE;
      FlushW = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl; define MEM_TIMEOUT_EN to also cover the watchdog.
module tb_mem_stall_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            MemReadM = 1'b0;
  logic            MemWriteM = 1'b0;
  logic [XLEN-1:0] AddrM = '0;
  logic [XLEN-1:0] WriteDataM = '0;
  logic            HazStallF = 1'b0;
  logic            HazStallD = 1'b0;
  logic            HazFlushE = 1'b0;
  logic            StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic [XLEN-1:0] ReadDataM;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid = 1'b0;
  logic [XLEN-1:0] rsp_rdata = '0;
  logic            BusErr;

  int checks = 0;
  int failures = 0;

  mem_stall_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .HazStallF(HazStallF), .HazStallD(HazStallD), .HazFlushE(HazFlushE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ReadDataM(ReadDataM),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    settle();
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (req_we !== 1'b0) begin failures++; $display("FAIL reset_req_we got=%b exp=0", req_we); end
    checks++; if (req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
    checks++; if (req_wdata !== 32'h0) begin failures++; $display("FAIL reset_req_wdata got=%h exp=0", req_wdata); end
    checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL reset_ReadDataM got=%h exp=0", ReadDataM); end
    checks++; if (BusErr !== 1'b0) begin failures++; $display("FAIL reset_BusErr got=%b exp=0", BusErr); end
    checks++; if ({StallF, StallD, StallE, StallM, FlushE, FlushW} !== 6'b0) begin
      failures++; $display("FAIL reset_stalls got=%b exp=000000", {StallF, StallD, StallE, StallM, FlushE, FlushW});
    end
  endtask

  task automatic test_single_load();
    int stalled;
    stalled = 0;
    // IDLE with a load present: frozen immediately, no request yet
    MemReadM = 1'b1; AddrM = 32'h100;
    settle();
    if (StallM === 1'b1) stalled++;
    checks++; if ({StallF, StallD, StallE, StallM, FlushW, FlushE} !== 6'b111110) begin
      failures++; $display("FAIL load_idle_stalls got=%b exp=111110", {StallF, StallD, StallE, StallM, FlushW, FlushE});
    end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL load_idle_req_valid got=%b exp=0", req_valid); end
    step();
    req_ready = 1'b1;
    settle();
    if (StallM === 1'b1) stalled++;
    checks++; if ({req_valid, req_we, req_addr} !== {2'b10, 32'h100}) begin
      failures++; $display("FAIL load_req got=%b/%b/%h exp=1/0/00000100", req_valid, req_we, req_addr);
    end
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
    settle();
    if (StallM === 1'b1) stalled++;
    checks++; if ({req_valid, FlushW} !== 2'b01) begin
      failures++; $display("FAIL load_wait got=%b exp=01", {req_valid, FlushW});
    end
    step();
    rsp_valid = 1'b0;
    settle();
    if (StallM === 1'b1) stalled++;
    checks++; if (ReadDataM !== 32'hDEADBEEF) begin failures++; $display("FAIL load_done_data got=%h exp=deadbeef", ReadDataM); end
    checks++; if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b0) begin
      failures++; $display("FAIL load_done_stalls got=%b exp=00000", {StallF, StallD, StallE, StallM, FlushW});
    end
    checks++; if (stalled != 3) begin failures++; $display("FAIL load_stall_count got=%0d exp=3", stalled); end
    step();
    MemReadM = 1'b0; AddrM = '0;
    settle();
  endtask

  task automatic test_store_backpressure();
    int accepts;
    int held;
    accepts = 0; held = 0;
    MemWriteM = 1'b1; AddrM = 32'h200; WriteDataM = 32'h55; req_ready = 1'b0;
    settle();
    step();
    // Change the M-stage inputs to prove the request registers do not follow them
    AddrM = 32'hFFF; WriteDataM = 32'hAAAA;
    for (int i = 0; i < 5; i++) begin
      req_ready = (i == 4);
      settle();
      if (req_valid === 1'b1) held++;
      if (req_valid === 1'b1 && req_ready) accepts++;
      checks++; if ({req_we, req_addr, req_wdata} !== {1'b1, 32'h200, 32'h55}) begin
        failures++; $display("FAIL store_req_stable cyc=%0d got=%b/%h/%h exp=1/00000200/00000055", i, req_we, req_addr, req_wdata);
      end
      step();
    end
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h0BADBAD0;
    settle();
    checks++; if ({req_valid, StallM} !== 2'b01) begin
      failures++; $display("FAIL store_wait got=%b exp=01", {req_valid, StallM});
    end
    step();
    rsp_valid = 1'b0;
    settle();
    checks++; if (held != 5) begin failures++; $display("FAIL store_valid_cycles got=%0d exp=5", held); end
    checks++; if (accepts != 1) begin failures++; $display("FAIL store_accepts got=%0d exp=1", accepts); end
    checks++; if ({StallM, ReadDataM} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("FAIL store_done got=%b/%h exp=0/deadbeef", StallM, ReadDataM);
    end
    step();
    MemWriteM = 1'b0; AddrM = '0; WriteDataM = '0;
    settle();
  endtask

  task automatic test_back_to_back();
    int accepts;
    accepts = 0;
    MemReadM = 1'b1; AddrM = 32'h300;
    settle();
    step();
    req_ready = 1'b1;
    settle();
    if (req_valid === 1'b1 && req_ready) accepts++;
    checks++; if (req_addr !== 32'h300) begin failures++; $display("FAIL b2b_addr1 got=%h exp=00000300", req_addr); end
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h11111111;
    step();
    rsp_valid = 1'b0; req_ready = 1'b1;
    settle();
    if (req_valid === 1'b1 && req_ready) accepts++;
    checks++; if ({req_valid, StallM, ReadDataM} !== {2'b00, 32'h11111111}) begin
      failures++; $display("FAIL b2b_done1 got=%b/%b/%h exp=0/0/11111111", req_valid, StallM, ReadDataM);
    end
    step();
    // Second load now in M, controller back in IDLE
    AddrM = 32'h304;
    settle();
    if (req_valid === 1'b1 && req_ready) accepts++;
    checks++; if ({req_valid, StallM} !== 2'b01) begin
      failures++; $display("FAIL b2b_idle2 got=%b exp=01", {req_valid, StallM});
    end
    step();
    settle();
    if (req_valid === 1'b1 && req_ready) accepts++;
    checks++; if ({req_valid, req_addr} !== {1'b1, 32'h304}) begin
      failures++; $display("FAIL b2b_req2 got=%b/%h exp=1/00000304", req_valid, req_addr);
    end
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h22222222;
    step();
    rsp_valid = 1'b0;
    settle();
    checks++; if ({StallM, ReadDataM} !== {1'b0, 32'h22222222}) begin
      failures++; $display("FAIL b2b_done2 got=%b/%h exp=0/22222222", StallM, ReadDataM);
    end
    checks++; if (accepts != 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", accepts); end
    step();
    MemReadM = 1'b0; AddrM = '0;
    settle();
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", StallM); end
  endtask

  task automatic test_hazard();
    HazStallF = 1'b1; HazStallD = 1'b1; HazFlushE = 1'b1;
    settle();
    checks++; if ({StallF, StallD, StallE, StallM, FlushE, FlushW} !== 6'b110010) begin
      failures++; $display("FAIL haz_pass got=%b exp=110010", {StallF, StallD, StallE, StallM, FlushE, FlushW});
    end
    MemReadM = 1'b1; AddrM = 32'h380;
    settle();
    checks++; if ({FlushE, StallE} !== 2'b01) begin failures++; $display("FAIL haz_idle_mask got=%b exp=01", {FlushE, StallE}); end
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    settle();
    checks++; if ({FlushE, StallF, StallD, FlushW} !== 4'b0111) begin
      failures++; $display("FAIL haz_wait_mask got=%b exp=0111", {FlushE, StallF, StallD, FlushW});
    end
    rsp_valid = 1'b1; rsp_rdata = 32'h33333333;
    step();
    rsp_valid = 1'b0;
    settle();
    checks++; if ({StallF, StallD, StallE, FlushE, ReadDataM} !== {4'b1101, 32'h33333333}) begin
      failures++; $display("FAIL haz_done_reassert got=%b/%h exp=1101/33333333", {StallF, StallD, StallE, FlushE}, ReadDataM);
    end
    step();
    MemReadM = 1'b0; HazStallF = 1'b0; HazStallD = 1'b0; HazFlushE = 1'b0;
    settle();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int waitStalls;
    waitStalls = 0;
    MemReadM = 1'b1; AddrM = 32'h500;
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (StallM === 1'b1 && req_valid === 1'b0) waitStalls++;
      step();
    end
    settle();
    checks++; if (waitStalls != 8) begin failures++; $display("FAIL timeout_wait_cycles got=%0d exp=8", waitStalls); end
    checks++; if ({StallM, BusErr, ReadDataM} !== {2'b01, 32'h0}) begin
      failures++; $display("FAIL timeout_done got=%b/%b/%h exp=0/1/00000000", StallM, BusErr, ReadDataM);
    end
    step();
    MemReadM = 1'b0;
    step();
    settle();
    checks++; if (BusErr !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", BusErr); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    MemReadM = 1'b1; AddrM = 32'h400;
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    settle();
    checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL rst_in_wait got=%b exp=1", StallM); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; MemReadM = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
    settle();
    checks++; if ({req_valid, StallF, StallD, StallE, StallM, FlushW, ReadDataM, BusErr} !== {6'b0, 32'h0, 1'b0}) begin
      failures++; $display("FAIL rst_after got=%b/%h/%b exp=000000/00000000/0",
                           {req_valid, StallF, StallD, StallE, StallM, FlushW}, ReadDataM, BusErr);
    end
    step();
    rsp_valid = 1'b0;
    settle();
    checks++; if ({req_valid, StallM, ReadDataM} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL rst_late_rsp got=%b/%b/%h exp=0/0/00000000", req_valid, StallM, ReadDataM);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_backpressure();
    test_back_to_back();
    test_hazard();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
